// File: rtl/kgp_seq_pkg.sv
// Shared definitions for the KGP_RISC instruction sequencer.
// Contents: opcode constants, the branch-class enum, the FSM state encoding,
// the flag register layout and the opcode-to-branch-class decoder.
package kgp_seq_pkg;

  localparam logic [5:0] OP_BR   = 6'b010010;
  localparam logic [5:0] OP_BLTZ = 6'b010011;
  localparam logic [5:0] OP_BZ   = 6'b010100;
  localparam logic [5:0] OP_BNZ  = 6'b010101;
  localparam logic [5:0] OP_B    = 6'b100000;
  localparam logic [5:0] OP_BL   = 6'b100001;
  localparam logic [5:0] OP_BCY  = 6'b100010;
  localparam logic [5:0] OP_BNCY = 6'b100011;
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic [1:0] {CLS_SEQ, CLS_COND, CLS_LABEL, CLS_REG} br_class_e;

  typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_EXEC, ST_UPDATE, ST_HALT} state_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic sign;
  } flags_t;

  // Any opcode not listed here is plain sequential (halt included; the
  // sequencer handles halt separately).
  function automatic br_class_e decode_class(input logic [5:0] op);
    br_class_e cls;
    case (op)
      OP_BLTZ, OP_BZ, OP_BNZ:           cls = CLS_COND;
      OP_B, OP_BL, OP_BCY, OP_BNCY:     cls = CLS_LABEL;
      OP_BR:                            cls = CLS_REG;
      default:                          cls = CLS_SEQ;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/pc_sequencer_next_pc_unit.sv
// next_pc_unit: combinational next-PC resolution.
// Inputs : cls_i (branch class), flags_i, pc_i, instr_i (current instruction),
//          rs_i (register jump target).
// Outputs: npc_o (next PC), taken_o (branch taken), is_link_o (instruction is bl).
module next_pc_unit
  import kgp_seq_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  br_class_e        cls_i,
  input  flags_t           flags_i,
  input  logic [PC_W-1:0]  pc_i,
  input  logic [31:0]      instr_i,
  input  logic [31:0]      rs_i,
  output logic [PC_W-1:0]  npc_o,
  output logic             taken_o,
  output logic             is_link_o
);

  logic [5:0]  op;
  logic [31:0] target;
  logic        taken;

  always_comb begin
    op     = instr_i[31:26];
    target = '0;
    taken  = 1'b0;
    case (cls_i)
      CLS_COND: begin
        target = {16'h0000, instr_i[15:0]};
        case (op)
          OP_BLTZ: taken = flags_i.sign;
          OP_BZ:   taken = flags_i.zero;
          OP_BNZ:  taken = ~flags_i.zero;
          default: taken = 1'b0;
        endcase
      end
      CLS_LABEL: begin
        target = {6'b000000, instr_i[25:0]};
        case (op)
          OP_B, OP_BL: taken = 1'b1;
          OP_BCY:      taken = flags_i.carry;
          OP_BNCY:     taken = ~flags_i.carry;
          default:     taken = 1'b0;
        endcase
      end
      CLS_REG: begin
        target = rs_i;
        taken  = 1'b1;
      end
      default: begin
        target = '0;
        taken  = 1'b0;
      end
    endcase
    // Targets and pc+1 both wrap to the PC width.
    npc_o     = taken ? target[PC_W-1:0] : pc_i + PC_W'(1);
    taken_o   = taken;
    is_link_o = (op == OP_BL);
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction sequencer for KGP_RISC. Owns the PC, the
// carry/zero/sign flag register and the retired-instruction counter.
// Ports: clk_i/rst_i (async active-high reset); start_i kicks off fetching;
// imem_req_o/imem_addr_o/imem_ack_i/imem_data_i fetch handshake; instr_o and
// exec_start_o/exec_done_i hand-off to the datapath; flag_we_i + alu_*_i load
// flags; rs_data_i register jump target; link_we_o/link_data_o bl link write;
// halted_o; retired_cnt_o.
module pc_sequencer
  import kgp_seq_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  output logic             imem_req_o,
  output logic [PC_W-1:0]  imem_addr_o,
  input  logic             imem_ack_i,
  input  logic [31:0]      imem_data_i,
  output logic [31:0]      instr_o,
  output logic             exec_start_o,
  input  logic             exec_done_i,
  input  logic             flag_we_i,
  input  logic             alu_carry_i,
  input  logic             alu_zero_i,
  input  logic             alu_sign_i,
  input  logic [31:0]      rs_data_i,
  output logic             link_we_o,
  output logic [31:0]      link_data_o,
  output logic             halted_o,
  output logic [31:0]      retired_cnt_o
);

  state_e           state_q;
  logic [PC_W-1:0]  pc_q;
  flags_t           flags_q;
  logic [31:0]      instr_q;
  logic [31:0]      rs_q;
  logic             req_q;
  logic             exec_start_q;
  logic             link_we_q;
  logic             halted_q;
  logic [31:0]      retired_q;

  br_class_e        cls;
  logic [PC_W-1:0]  npc_d;
  logic             taken;
  logic             is_link;
  logic             is_halt;
  logic [PC_W-1:0]  pc_inc;

  assign cls     = decode_class(instr_q[31:26]);
  assign is_halt = (instr_q[31:26] == OP_HALT);
  assign pc_inc  = pc_q + PC_W'(1);

  next_pc_unit #(.PC_W(PC_W)) u_npc (
    .cls_i     (cls),
    .flags_i   (flags_q),
    .pc_i      (pc_q),
    .instr_i   (instr_q),
    .rs_i      (rs_q),
    .npc_o     (npc_d),
    .taken_o   (taken),
    .is_link_o (is_link)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      flags_q      <= '0;
      instr_q      <= '0;
      rs_q         <= '0;
      req_q        <= 1'b0;
      exec_start_q <= 1'b0;
      link_we_q    <= 1'b0;
      halted_q     <= 1'b0;
      retired_q    <= '0;
    end else begin
      exec_start_q <= 1'b0;
      link_we_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q <= ST_FETCH;
            req_q   <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (imem_ack_i) begin
            instr_q      <= imem_data_i;
            req_q        <= 1'b0;
            exec_start_q <= 1'b1;
            state_q      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (flag_we_i) begin
            flags_q <= '{carry: alu_carry_i, zero: alu_zero_i, sign: alu_sign_i};
          end
          if (exec_done_i) begin
            rs_q      <= rs_data_i;
            // Pulse lands in the UPDATE cycle, while pc still holds this instruction's address.
            link_we_q <= is_link;
            state_q   <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          retired_q <= retired_q + 32'd1;
          if (is_halt) begin
            halted_q <= 1'b1;
            state_q  <= ST_HALT;
          end else begin
            pc_q    <= npc_d;
            req_q   <= 1'b1;
            state_q <= ST_FETCH;
          end
        end
        ST_HALT: begin
          state_q <= ST_HALT;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = pc_q;
  assign instr_o       = instr_q;
  assign exec_start_o  = exec_start_q;
  assign link_we_o     = link_we_q;
  assign link_data_o   = 32'(pc_inc);
  assign halted_o      = halted_q;
  assign retired_cnt_o = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clk, rst, start, imem_ack, exec_done, flag_we;
  logic        alu_carry, alu_zero, alu_sign;
  logic [31:0] imem_data, rs_data;

  logic        req, exec_start, link_we, halted;
  logic [31:0] addr, instr, link_data, retired;
  logic        req4, exec_start4, link_we4, halted4;
  logic [3:0]  addr4;
  logic [31:0] instr4, link_data4, retired4;

  pc_sequencer #(.PC_W(32), .RESET_PC(32'h0)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .imem_req_o(req), .imem_addr_o(addr), .imem_ack_i(imem_ack), .imem_data_i(imem_data),
    .instr_o(instr), .exec_start_o(exec_start), .exec_done_i(exec_done),
    .flag_we_i(flag_we), .alu_carry_i(alu_carry), .alu_zero_i(alu_zero), .alu_sign_i(alu_sign),
    .rs_data_i(rs_data), .link_we_o(link_we), .link_data_o(link_data),
    .halted_o(halted), .retired_cnt_o(retired)
  );

  // Narrow-PC copy on the same stimulus; its timing is identical, only PC values differ.
  pc_sequencer #(.PC_W(4), .RESET_PC(4'h0)) dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .imem_req_o(req4), .imem_addr_o(addr4), .imem_ack_i(imem_ack), .imem_data_i(imem_data),
    .instr_o(instr4), .exec_start_o(exec_start4), .exec_done_i(exec_done),
    .flag_we_i(flag_we), .alu_carry_i(alu_carry), .alu_zero_i(alu_zero), .alu_sign_i(alu_sign),
    .rs_data_i(rs_data), .link_we_o(link_we4), .link_data_o(link_data4),
    .halted_o(halted4), .retired_cnt_o(retired4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad = 0;

  // Reference model state: PCs as plain integers, flags, retired count.
  longint unsigned m_pc, m_pc4;
  bit              m_c, m_z, m_s;
  int unsigned     m_ret;

  // Expected outputs for the current cycle.
  logic        chk_en;
  logic        exp_req, exp_exec_start, exp_link_we, exp_halted;
  logic [31:0] exp_addr, exp_addr4, exp_instr, exp_retired, exp_link_data, exp_link_data4;
  logic [31:0] last_link;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    total++;
    if (act !== req_v) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req_v, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("imem_req", 32'(req), 32'(exp_req));
      cmp("imem_addr", addr, exp_addr);
      cmp("imem_req_w4", 32'(req4), 32'(exp_req));
      cmp("imem_addr_w4", 32'(addr4), exp_addr4);
      cmp("exec_start", 32'(exec_start), 32'(exp_exec_start));
      cmp("link_we", 32'(link_we), 32'(exp_link_we));
      cmp("halted", 32'(halted), 32'(exp_halted));
      cmp("halted_w4", 32'(halted4), 32'(exp_halted));
      cmp("retired_cnt", retired, exp_retired);
      cmp("instr", instr, exp_instr);
      if (exp_link_we) begin
        cmp("link_data", link_data, exp_link_data);
        cmp("link_data_w4", link_data4, exp_link_data4);
      end
      if (link_we) last_link = link_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Next PC from the instruction-set rules, for a PC of width w bits.
  function automatic longint unsigned m_npc(input longint unsigned pc, input int w,
                                           input logic [31:0] iw, input logic [31:0] rs);
    longint unsigned mask = (64'd1 << w) - 64'd1;
    logic [5:0]      op   = iw[31:26];
    bit              tk   = 1'b0;
    longint unsigned tgt  = 0;
    case (op)
      6'h13: begin tk = m_s;  tgt = longint'(iw[15:0]); end
      6'h14: begin tk = m_z;  tgt = longint'(iw[15:0]); end
      6'h15: begin tk = !m_z; tgt = longint'(iw[15:0]); end
      6'h20, 6'h21: begin tk = 1'b1; tgt = longint'(iw[25:0]); end
      6'h22: begin tk = m_c;  tgt = longint'(iw[25:0]); end
      6'h23: begin tk = !m_c; tgt = longint'(iw[25:0]); end
      6'h12: begin tk = 1'b1; tgt = longint'(rs); end
      default: tk = 1'b0;
    endcase
    return tk ? (tgt & mask) : ((pc + 1) & mask);
  endfunction

  task automatic model_reset();
    m_pc = 0; m_pc4 = 0; m_c = 0; m_z = 0; m_s = 0; m_ret = 0;
    exp_req = 0; exp_addr = 0; exp_addr4 = 0; exp_exec_start = 0; exp_link_we = 0;
    exp_halted = 0; exp_retired = 0; exp_instr = 0; exp_link_data = 0; exp_link_data4 = 0;
  endtask

  task automatic do_reset();
    #2;
    rst = 1; start = 0; imem_ack = 0; exec_done = 0; flag_we = 0;
    model_reset();
    tick();
    tick();
    rst = 0;
    tick();
  endtask

  task automatic go();
    start = 1;
    tick();
    start = 0;
    exp_req = 1;
  endtask

  // One instruction from its first FETCH cycle to the first cycle after UPDATE.
  task automatic run_instr(input logic [31:0] iw, input int ack_lat, input int done_lat,
                           input bit rnd, input bit fwe, input logic [2:0] fl,
                           input logic [31:0] rs);
    logic [5:0] op = iw[31:26];
    for (int k = 0; k <= ack_lat; k++) begin
      imem_ack  = (k == ack_lat);
      imem_data = (k == ack_lat) ? iw : $urandom;
      start     = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      flag_we   = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      {alu_carry, alu_zero, alu_sign} = 3'($urandom);
      tick();
      if (k == ack_lat) begin
        exp_req = 0; exp_exec_start = 1; exp_instr = iw;
      end
    end
    imem_ack = 0;
    imem_data = $urandom;
    for (int j = 0; j <= done_lat; j++) begin
      exec_done = (j == done_lat);
      rs_data   = (j == done_lat) ? rs : $urandom;
      start     = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      flag_we   = rnd ? 1'($urandom_range(0, 1)) : (fwe && j == 0);
      {alu_carry, alu_zero, alu_sign} = rnd ? 3'($urandom) : fl;
      if (flag_we) {m_c, m_z, m_s} = {alu_carry, alu_zero, alu_sign};
      tick();
      exp_exec_start = 0;
      if (j == done_lat) begin
        exp_link_we    = (op == 6'h21);
        exp_link_data  = 32'((m_pc + 1) & 64'hFFFF_FFFF);
        exp_link_data4 = 32'((m_pc4 + 1) & 64'hF);
      end
    end
    // UPDATE cycle: datapath noise here must not reach the flags.
    exec_done = 0;
    flag_we   = 1'($urandom_range(0, 1));
    {alu_carry, alu_zero, alu_sign} = 3'($urandom);
    rs_data = $urandom;
    m_ret++;
    if (op != 6'h3f) begin
      m_pc  = m_npc(m_pc, 32, iw, rs);
      m_pc4 = m_npc(m_pc4, 4, iw, rs);
    end
    tick();
    flag_we = 0; start = 0;
    exp_link_we = 0;
    exp_retired = m_ret;
    if (op == 6'h3f) begin
      exp_halted = 1;
    end else begin
      exp_req = 1;
      exp_addr = 32'(m_pc);
      exp_addr4 = 32'(m_pc4);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] op;
    case ($urandom_range(0, 8))
      0, 1:    op = 6'($urandom_range(0, 15));
      2:       op = 6'h13;
      3:       op = 6'h14;
      4:       op = 6'h15;
      5:       op = $urandom_range(0, 1) ? 6'h20 : 6'h21;
      6:       op = 6'h22;
      7:       op = 6'h23;
      default: op = 6'h12;
    endcase
    return {op, 26'($urandom)};
  endfunction

  initial begin
    rst = 1; start = 0; imem_ack = 0; imem_data = 0; exec_done = 0; flag_we = 0;
    alu_carry = 0; alu_zero = 0; alu_sign = 0; rs_data = 0; last_link = 0;
    model_reset();
    chk_en = 1;
    tick();
    tick();
    rst = 0;
    tick();
    cmp("lit_reset_addr", addr, 32'h0);
    cmp("lit_reset_req", 32'(req), 32'h0);
    go();

    // Three ALU ops, ack two cycles late.
    for (int i = 0; i < 3; i++) run_instr({6'h00, 26'h0}, 2, 0, 0, 0, 3'b000, 32'h0);
    cmp("lit_seq_addr", addr, 32'h3);
    cmp("lit_seq_retired", retired, 32'h3);
    // add sets zero, bz taken, bnz falls through.
    run_instr({6'h01, 26'h0}, 0, 1, 0, 1, 3'b010, 32'h0);
    run_instr({6'h14, 10'h0, 16'h0040}, 0, 0, 0, 0, 3'b000, 32'h0);
    cmp("lit_bz_taken", addr, 32'h40);
    run_instr({6'h15, 10'h0, 16'h0040}, 1, 0, 0, 0, 3'b000, 32'h0);
    cmp("lit_bnz_fall", addr, 32'h41);
    // carry=1 then bncy falls through.
    run_instr({6'h01, 26'h0}, 0, 0, 0, 1, 3'b100, 32'h0);
    run_instr({6'h23, 26'h123}, 0, 2, 0, 0, 3'b000, 32'h0);
    cmp("lit_bncy_fall", addr, 32'h43);
    run_instr({6'h20, 26'd5}, 0, 0, 0, 0, 3'b000, 32'h0);
    cmp("lit_b_to_5", addr, 32'h5);
    run_instr({6'h21, 26'h200}, 1, 1, 0, 0, 3'b000, 32'h0);
    cmp("lit_bl_link", last_link, 32'h6);
    cmp("lit_bl_target", addr, 32'h200);
    run_instr({6'h12, 26'h0}, 0, 0, 0, 0, 3'b000, 32'h1234);
    cmp("lit_br_target", addr, 32'h1234);
    // Narrow PC wrap: pc=15 plus one SEQ op.
    run_instr({6'h20, 26'd15}, 0, 0, 0, 0, 3'b000, 32'h0);
    run_instr({6'h02, 26'h0}, 0, 0, 0, 0, 3'b000, 32'h0);
    cmp("lit_wrap_w4", 32'(addr4), 32'h0);
    cmp("lit_wrap_w32", addr, 32'h10);

    for (int i = 0; i < 150; i++)
      run_instr(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 3), 1, 0, 3'b000, $urandom);

    // Reset in the middle of an EXEC.
    imem_ack = 1;
    imem_data = {6'h01, 26'h0};
    tick();
    imem_ack = 0;
    exp_req = 0; exp_exec_start = 1; exp_instr = {6'h01, 26'h0};
    do_reset();
    cmp("lit_rst_addr", addr, 32'h0);
    cmp("lit_rst_retired", retired, 32'h0);
    cmp("lit_rst_req", 32'(req), 32'h0);
    cmp("lit_rst_halted", 32'(halted), 32'h0);
    go();
    cmp("lit_restart_addr", addr, 32'h0);

    // Halt at pc=7, then prod it.
    run_instr({6'h20, 26'd7}, 0, 0, 0, 0, 3'b000, 32'h0);
    run_instr({6'h3f, 26'h0}, 1, 0, 0, 0, 3'b000, 32'h0);
    for (int i = 0; i < 6; i++) begin
      start = 1; imem_ack = 1; imem_data = $urandom; exec_done = 1;
      tick();
    end
    start = 0; imem_ack = 0; exec_done = 0;
    tick();
    cmp("lit_halt_addr", addr, 32'h7);
    cmp("lit_halt_flag", 32'(halted), 32'h1);
    cmp("lit_halt_req", 32'(req), 32'h0);
    cmp("lit_halt_retired", retired, 32'h2);

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
